// File: rtl/adpll_lock_ctrl.sv
// Acquisition/lock sequencer for the ring-oscillator ADPLL: reset hold, coarse bias search, lock/unlock.
// Optional watchdog on ACQUIRE/TRACK enabled by defining ADPLL_LOCK_TIMEOUT_EN.
module adpll_lock_ctrl #(
  parameter int RO_WIDTH     = 5,
  parameter int PDET_WIDTH   = 8,
  parameter int BIAS_INIT    = 16,
  parameter int RST_CYCLES   = 16,
  parameter int WIN          = 8,
  parameter int COARSE_TOL   = 32,
  parameter int LOCK_TOL     = 2,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_TOL   = 8,
  parameter int UNLOCK_COUNT = 4
`ifdef ADPLL_LOCK_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 2**20
`endif
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_n_i,
  input  logic                  enable_i,
  input  logic [PDET_WIDTH-1:0] error_i,
  input  logic                  error_valid_i,
  output logic                  pll_reset_o,
  output logic [RO_WIDTH-1:0]   bias_o,
  output logic                  locked_o,
  output logic                  lock_lost_o,
  output logic                  fail_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLL_RST = 3'd1,
    S_ACQUIRE = 3'd2,
    S_TRACK   = 3'd3,
    S_LOCKED  = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  localparam int EW   = PDET_WIDTH + 1;
  localparam int CM0  = (RST_CYCLES > WIN) ? RST_CYCLES : WIN;
  localparam int CM1  = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CMAX = (CM0 > CM1) ? CM0 : CM1;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0]        L_RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]        L_WIN      = CW'(WIN);
  localparam logic [CW-1:0]        L_LOCK_CNT = CW'(LOCK_COUNT);
  localparam logic [CW-1:0]        L_UNL_CNT  = CW'(UNLOCK_COUNT);
  localparam logic signed [EW-1:0] L_CPOS     = EW'(COARSE_TOL);
  localparam logic signed [EW-1:0] L_CNEG     = EW'(-COARSE_TOL);
  localparam logic [EW-1:0]        L_LOCK_TOL = EW'(LOCK_TOL);
  localparam logic [EW-1:0]        L_UNL_TOL  = EW'(UNLOCK_TOL);
  localparam logic [RO_WIDTH-1:0]  L_BIAS0    = RO_WIDTH'(BIAS_INIT);
  localparam logic [RO_WIDTH-1:0]  L_BIAS_MAX = {RO_WIDTH{1'b1}};

  state_t               r_state;
  logic                 r_pll_reset;
  logic [RO_WIDTH-1:0]  r_bias;
  logic                 r_locked;
  logic                 r_lock_lost;
  logic                 r_fail;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_pos;
  logic [CW-1:0]        r_neg;

  // Sign-extend one bit so the most negative sample has a representable magnitude.
  logic signed [EW-1:0] w_err;
  logic [EW-1:0]        w_abs;
  logic                 w_pos, w_neg, w_good, w_bad;
  logic [CW-1:0]        w_cnt_inc, w_pos_inc, w_neg_inc;

  assign w_err     = {error_i[PDET_WIDTH-1], error_i};
  assign w_abs     = w_err[EW-1] ? (-w_err) : w_err;
  assign w_pos     = w_err > L_CPOS;
  assign w_neg     = w_err < L_CNEG;
  assign w_good    = w_abs <= L_LOCK_TOL;
  assign w_bad     = w_abs > L_UNL_TOL;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_pos_inc = (w_pos && !(&r_pos)) ? r_pos + 1'b1 : r_pos;
  assign w_neg_inc = (w_neg && !(&r_neg)) ? r_neg + 1'b1 : r_neg;

`ifdef ADPLL_LOCK_TIMEOUT_EN
  localparam logic [23:0] L_TO_LAST = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] r_wdog;
`endif

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= S_IDLE;
      r_pll_reset <= 1'b1;
      r_bias      <= L_BIAS0;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
      r_fail      <= 1'b0;
      r_cnt       <= '0;
      r_pos       <= '0;
      r_neg       <= '0;
`ifdef ADPLL_LOCK_TIMEOUT_EN
      r_wdog      <= '0;
`endif
    end else begin
      r_lock_lost <= 1'b0;
      if (!enable_i) begin
        r_state     <= S_IDLE;
        r_pll_reset <= 1'b1;
        r_bias      <= L_BIAS0;
        r_locked    <= 1'b0;
        r_fail      <= 1'b0;
        r_cnt       <= '0;
        r_pos       <= '0;
        r_neg       <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state     <= S_PLL_RST;
            r_pll_reset <= 1'b1;
            r_cnt       <= '0;
          end
          S_PLL_RST: begin
            if (r_cnt == L_RST_LAST) begin
              r_state     <= S_ACQUIRE;
              r_pll_reset <= 1'b0;
              r_cnt       <= '0;
              r_pos       <= '0;
              r_neg       <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_ACQUIRE: begin
            if (error_valid_i) begin
              if (w_cnt_inc == L_WIN) begin
                r_cnt <= '0;
                r_pos <= '0;
                r_neg <= '0;
                if (w_pos_inc == L_WIN || w_neg_inc == L_WIN) begin
                  r_pll_reset <= 1'b1;
                  // A step past either end of the code range means the ring cannot reach the target.
                  if ((w_pos_inc == L_WIN && r_bias == '0) ||
                      (w_neg_inc == L_WIN && r_bias == L_BIAS_MAX)) begin
                    r_state <= S_FAIL;
                    r_fail  <= 1'b1;
                  end else begin
                    r_state <= S_PLL_RST;
                    r_bias  <= (w_pos_inc == L_WIN) ? r_bias - 1'b1 : r_bias + 1'b1;
                  end
                end else begin
                  r_state <= S_TRACK;
                end
              end else begin
                r_cnt <= w_cnt_inc;
                r_pos <= w_pos_inc;
                r_neg <= w_neg_inc;
              end
            end
          end
          S_TRACK: begin
            if (error_valid_i) begin
              if (!w_good) begin
                r_cnt <= '0;
              end else if (w_cnt_inc == L_LOCK_CNT) begin
                r_state  <= S_LOCKED;
                r_locked <= 1'b1;
                r_cnt    <= '0;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
          end
          S_LOCKED: begin
            if (error_valid_i) begin
              if (!w_bad) begin
                r_cnt <= '0;
              end else if (w_cnt_inc == L_UNL_CNT) begin
                r_state     <= S_ACQUIRE;
                r_locked    <= 1'b0;
                r_lock_lost <= 1'b1;
                r_cnt       <= '0;
                r_pos       <= '0;
                r_neg       <= '0;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
          end
          S_FAIL: begin
            r_fail      <= 1'b1;
            r_pll_reset <= 1'b1;
          end
          default: begin
            r_state     <= S_IDLE;
            r_pll_reset <= 1'b1;
          end
        endcase
`ifdef ADPLL_LOCK_TIMEOUT_EN
        if ((r_state == S_ACQUIRE || r_state == S_TRACK) && r_wdog == L_TO_LAST) begin
          r_state     <= S_FAIL;
          r_fail      <= 1'b1;
          r_pll_reset <= 1'b1;
          r_cnt       <= '0;
          r_pos       <= '0;
          r_neg       <= '0;
        end
`endif
      end
`ifdef ADPLL_LOCK_TIMEOUT_EN
      if (enable_i && (r_state == S_ACQUIRE || r_state == S_TRACK))
        r_wdog <= (r_wdog == L_TO_LAST) ? r_wdog : r_wdog + 1'b1;
      else
        r_wdog <= '0;
`endif
    end
  end

  assign pll_reset_o = r_pll_reset;
  assign bias_o      = r_bias;
  assign locked_o    = r_locked;
  assign lock_lost_o = r_lock_lost;
  assign fail_o      = r_fail;
  assign state_o     = r_state;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Directed bench for adpll_lock_ctrl: a default instance plus a BIAS_INIT=0 instance sharing stimulus.
module tb_adpll_lock_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] error;
  logic       valid;

  logic       pll_reset, locked, lock_lost, fail;
  logic [4:0] bias;
  logic [2:0] state;
  logic       z_pll_reset, z_locked, z_lock_lost, z_fail;
  logic [4:0] z_bias;
  logic [2:0] z_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adpll_lock_ctrl u_dut (
    .fpga_clk_i(clk), .reset_n_i(reset_n), .enable_i(enable),
    .error_i(error), .error_valid_i(valid),
    .pll_reset_o(pll_reset), .bias_o(bias), .locked_o(locked),
    .lock_lost_o(lock_lost), .fail_o(fail), .state_o(state)
  );

  adpll_lock_ctrl #(.BIAS_INIT(0)) u_dut_z (
    .fpga_clk_i(clk), .reset_n_i(reset_n), .enable_i(enable),
    .error_i(error), .error_valid_i(valid),
    .pll_reset_o(z_pll_reset), .bias_o(z_bias), .locked_o(z_locked),
    .lock_lost_o(z_lock_lost), .fail_o(z_fail), .state_o(z_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input int e);
    error = 8'(e);
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    $display("strobe error=%0d -> state=%0d bias=%0d locked=%0d lost=%0d fail=%0d",
             e, state, bias, locked, lock_lost, fail);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    error   = '0;
    valid   = 1'b0;
    tick(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_pll_reset", 32'(pll_reset), 1);
    chk("rst_bias", 32'(bias), 16);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_lock_lost", 32'(lock_lost), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_bias_z", 32'(z_bias), 0);

    // Bring-up: 16 cycles of PLL_RST; strobes during it are ignored
    reset_n = 1'b1;
    tick(1);
    enable = 1'b1;
    tick(1);
    chk("pllrst_state", 32'(state), 1);
    chk("pllrst_reset", 32'(pll_reset), 1);
    error = 8'(40);
    valid = 1'b1;
    tick(14);
    valid = 1'b0;
    tick(1);
    chk("pllrst_16th_state", 32'(state), 1);
    tick(1);
    chk("acq_state", 32'(state), 2);
    chk("acq_pll_reset", 32'(pll_reset), 0);
    chk("acq_bias", 32'(bias), 16);

    // Coarse step down on a full window of positive offsets
    for (int i = 0; i < 7; i++) strobe(40);
    chk("win7_state", 32'(state), 2);
    strobe(40);
    chk("dn_bias", 32'(bias), 15);
    chk("dn_state", 32'(state), 1);
    chk("dn_pll_reset", 32'(pll_reset), 1);
    chk("z_fail_low", 32'(z_state), 5);
    tick(15);
    chk("dn_rst_15", 32'(state), 1);
    tick(1);
    chk("dn_acq", 32'(state), 2);

    // Coarse step up on a full window of negative offsets
    for (int i = 0; i < 8; i++) strobe(-40);
    chk("up_bias", 32'(bias), 16);
    chk("up_state", 32'(state), 1);
    tick(16);
    chk("up_acq", 32'(state), 2);

    // Mixed window falls through to TRACK
    for (int i = 0; i < 7; i++) strobe(40);
    strobe(0);
    chk("track_state", 32'(state), 3);
    chk("track_bias", 32'(bias), 16);

    // A bad sample restarts the good run
    for (int i = 0; i < 15; i++) strobe(1);
    strobe(3);
    chk("track_reset_run", 32'(state), 3);
    for (int i = 0; i < 15; i++) strobe((i % 2 == 0) ? 1 : -2);
    chk("track_15_good", 32'(state), 3);
    chk("track_15_unlocked", 32'(locked), 0);
    strobe(1);
    chk("lock_state", 32'(state), 4);
    chk("lock_locked", 32'(locked), 1);

    // Loss of lock, including the most negative sample and the |error|==UNLOCK_TOL edge
    for (int i = 0; i < 3; i++) strobe(-128);
    strobe(8);
    chk("lock_hold_state", 32'(state), 4);
    for (int i = 0; i < 3; i++) strobe(-128);
    chk("lock_3bad", 32'(locked), 1);
    strobe(-128);
    chk("unlock_state", 32'(state), 2);
    chk("unlock_locked", 32'(locked), 0);
    chk("unlock_pulse", 32'(lock_lost), 1);
    chk("unlock_bias", 32'(bias), 16);
    chk("unlock_no_pllrst", 32'(pll_reset), 0);
    tick(1);
    chk("unlock_pulse_end", 32'(lock_lost), 0);

    // Disable reloads the initial bias
    for (int i = 0; i < 8; i++) strobe(40);
    chk("pre_dis_bias", 32'(bias), 15);
    enable = 1'b0;
    tick(1);
    chk("dis_state", 32'(state), 0);
    chk("dis_bias", 32'(bias), 16);
    chk("dis_pll_reset", 32'(pll_reset), 1);
    chk("dis_z_state", 32'(z_state), 0);
    chk("dis_z_fail", 32'(z_fail), 0);

    // Bias underflow at code 0 goes to FAIL and holds until disabled
    enable = 1'b1;
    tick(17);
    chk("z_acq", 32'(z_state), 2);
    for (int i = 0; i < 8; i++) strobe(100);
    chk("z_fail_state", 32'(z_state), 5);
    chk("z_fail_flag", 32'(z_fail), 1);
    chk("z_fail_pllrst", 32'(z_pll_reset), 1);
    chk("z_fail_bias", 32'(z_bias), 0);
    chk("main_bias_dn", 32'(bias), 15);
    tick(3);
    chk("z_fail_held", 32'(z_state), 5);
    enable = 1'b0;
    tick(1);
    chk("z_idle_state", 32'(z_state), 0);
    chk("z_idle_fail", 32'(z_fail), 0);

    // Asynchronous reset mid-window discards the partial window
    enable = 1'b1;
    tick(17);
    chk("ar_acq", 32'(state), 2);
    for (int i = 0; i < 4; i++) strobe(40);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_state", 32'(state), 0);
    chk("ar_bias", 32'(bias), 16);
    chk("ar_pll_reset", 32'(pll_reset), 1);
    reset_n = 1'b1;
    tick(17);
    chk("ar_reacq", 32'(state), 2);
    for (int i = 0; i < 4; i++) strobe(40);
    chk("ar_half_window", 32'(state), 2);
    for (int i = 0; i < 4; i++) strobe(40);
    chk("ar_full_state", 32'(state), 1);
    chk("ar_full_bias", 32'(bias), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
